trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Trap sequencer sitting between the pipeline and the machine-mode CSR file.
//  Accepts synchronous exceptions, MRET and level IRQs, and picks one by priority.
//  Sequences a pipeline flush, the mepc/mstatus save (or restore), then a PC redirect.
//  Drives the CSR file's save_epc/pc inputs and the fetch-stage redirect.
// PARAMETERS
//  NUM_IRQ     4             number of level-sensitive interrupt lines (1..16)
//  MTVEC_BASE  32'h0000_0100 trap vector base; bits [1:0] must be 0
// PORTS
//  clk             in   1        single clock; all state changes on posedge
//  rst             in   1        synchronous reset, active-high
//  exc_valid_i     in   1        synchronous exception from decode/execute
//  exc_code_i      in   4        exception cause code
//  exc_pc_i        in   32       PC of the faulting instruction
//  mret_i          in   1        MRET retiring
//  irq_i           in   NUM_IRQ  interrupt request lines, level
//  mie_i           in   1        mstatus.MIE from CSR file
//  next_pc_i       in   32       PC of next unretired instr (interrupt epc)
//  epc_i           in   32       current mepc from CSR file (MRET target)
//  flush_req_o     out  1        request pipeline drain/flush
//  flush_ack_i     in   1        pipeline drained
//  save_epc_o      out  1        1-cycle pulse: CSR latches mepc and stacks MIE
//  epc_pc_o        out  32       value for CSR pc input; valid with save_epc_o
//  mret_restore_o  out  1        1-cycle pulse: CSR restores MIE from MPIE
//  cause_o         out  32       mcause value; valid with save_epc_o
//  redirect_o      out  1        1-cycle pulse: fetch jumps to redirect_pc_o
//  redirect_pc_o   out  32       redirect target
//  busy_o          out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0 after the first posedge with rst=1.
//   Reset applied mid-sequence drops the captured event; no partial pulses follow.
//  FSM states: IDLE, FLUSH, SAVE, RESTORE, JUMP.
//  IDLE: events are sampled only here. Priority, highest first:
//   - exc_valid_i
//   - mret_i
//   - (mie_i and |irq_i), lowest irq index wins
//   Winner is captured into internal regs: kind, cause, epc, target. Next state is FLUSH.
//  Inputs are ignored while busy_o=1. IRQs still asserted on return to IDLE are taken then.
//  Captured values:
//   - exception: cause = {28'h0, exc_code_i}; epc = exc_pc_i; target = MTVEC_BASE
//   - interrupt idx k: cause = 32'h8000_0000 | (16+k); epc = next_pc_i
//   - mret: target = epc_i, sampled in the RESTORE cycle
//  FLUSH: flush_req_o=1. flush_ack_i is sampled only in FLUSH, so FLUSH lasts at
//   least 1 cycle; ack seen -> SAVE (trap) or RESTORE (mret). Ack outside FLUSH is ignored.
//  SAVE: save_epc_o=1, epc_pc_o=epc, cause_o=cause, for exactly 1 cycle -> JUMP.
//  RESTORE: mret_restore_o=1 for 1 cycle; latch epc_i as target -> JUMP.
//  JUMP: redirect_o=1, redirect_pc_o=target, for 1 cycle -> IDLE.
//  Latency: event at edge N -> flush_req_o from N+1.
//   Ack at edge M -> save/restore pulse at M+1 -> redirect at M+2.
//  Data outputs are 0 whenever their strobe is low.
// CONFIGURATION
//  VECTORED_MTVEC_EN defined:
//   - interrupt target = MTVEC_BASE + 4*(16+k)
//   - exceptions still use MTVEC_BASE
//  Undefined: every trap targets MTVEC_BASE (direct mode).
// TESTING
//  1. exc_valid_i=1, exc_code_i=2, exc_pc_i=0x80 in IDLE, ack after 3 cycles ->
//     save_epc_o with epc_pc_o=0x80, cause_o=0x2; then redirect_pc_o=0x100.
//  2. irq_i=4'b0110, mie_i=1, next_pc_i=0x44 ->
//     cause_o=0x8000_0011, epc_pc_o=0x44;
//     redirect_pc_o=0x144 with VECTORED_MTVEC_EN, 0x100 without.
//  3. irq_i=4'b0001 with mie_i=0 ->
//     no flush_req_o and busy_o stays 0 for 20 cycles.
//  4. mret_i=1, epc_i=0x200, immediate ack ->
//     mret_restore_o pulse, then redirect_pc_o=0x200; save_epc_o never asserts.
//  5. exc_valid_i, mret_i and irq_i[0] together -> exception cause chosen.
//     Second exc_valid_i while busy_o=1 -> ignored; exactly one redirect.
//  6. rst=1 while in FLUSH ->
//     all outputs 0 next cycle, state IDLE; ack after reset produces no pulses.

Source files
------------

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
// Trap sequencer that sits between the pipeline and the machine-mode CSR file.
// It takes synchronous exceptions, MRET and level-sensitive interrupts, picks
// one event by priority, and then runs these steps in order:
//   1. request a pipeline flush and wait for the flush acknowledge,
//   2. save mepc/mcause (for a trap) or restore MIE (for an MRET),
//   3. redirect fetch to the target PC.
//
// Optional feature macro: VECTORED_MTVEC_EN
//   defined   : interrupt k vectors to MTVEC_BASE + 4*(16+k)
//   undefined : every trap goes to MTVEC_BASE (direct mode)
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   exc_valid_i     exception request (highest priority)
//   exc_code_i      exception cause code
//   exc_pc_i        PC of the faulting instruction
//   mret_i          MRET retiring
//   irq_i           level interrupt lines; the lowest index wins
//   mie_i           global interrupt enable (mstatus.MIE)
//   next_pc_i       PC saved as the interrupt epc
//   epc_i           current mepc; used as the MRET target
//   flush_req_o     asks the pipeline to drain
//   flush_ack_i     pipeline drained (only sampled in FLUSH)
//   save_epc_o      1-cycle pulse; epc_pc_o and cause_o are valid with it
//   epc_pc_o        epc value for the CSR file
//   mret_restore_o  1-cycle pulse; the CSR file restores MIE from MPIE
//   cause_o         mcause value
//   redirect_o      1-cycle pulse; redirect_pc_o is valid with it
//   redirect_pc_o   fetch redirect target
//   busy_o          high in every state except IDLE
// ---------------------------------------------------------------------------
module trap_ctrl #(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] MTVEC_BASE = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc_valid_i,
    input  logic [3:0]         exc_code_i,
    input  logic [31:0]        exc_pc_i,
    input  logic               mret_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               mie_i,
    input  logic [31:0]        next_pc_i,
    input  logic [31:0]        epc_i,
    output logic               flush_req_o,
    input  logic               flush_ack_i,
    output logic               save_epc_o,
    output logic [31:0]        epc_pc_o,
    output logic               mret_restore_o,
    output logic [31:0]        cause_o,
    output logic               redirect_o,
    output logic [31:0]        redirect_pc_o,
    output logic               busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        SAVE,
        RESTORE,
        JUMP
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        is_mret_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [31:0] target_q;

    logic        take_exc;
    logic        take_mret;
    logic        take_irq;
    logic        take_any;
    logic [4:0]  irq_idx;
    logic [31:0] irq_cause;
    logic [31:0] irq_target;

    // Event arbitration: exception beats MRET, MRET beats an enabled IRQ.
    // The loop runs from the top index down, so the lowest pending index
    // is the one left in irq_idx.
    always_comb begin
        irq_idx = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_i[i]) begin
                irq_idx = 5'(i);
            end
        end
        take_exc  = exc_valid_i;
        take_mret = !exc_valid_i && mret_i;
        take_irq  = !exc_valid_i && !mret_i && mie_i && (|irq_i);
        take_any  = take_exc || take_mret || take_irq;
        irq_cause = 32'h8000_0010 + {27'd0, irq_idx};
`ifdef VECTORED_MTVEC_EN
        irq_target = MTVEC_BASE + 32'h0000_0040 + {25'd0, irq_idx, 2'b00};
`else
        irq_target = MTVEC_BASE;
`endif
    end

    // State register plus capture of the winning event. Events are only
    // captured in IDLE. The MRET target is taken from epc_i in RESTORE,
    // so any CSR write to mepc made during the flush is still honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_mret_q <= 1'b0;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
            target_q  <= 32'd0;
        end else begin
            state <= next_state;
            if (state == IDLE && take_any) begin
                is_mret_q <= take_mret;
                if (take_exc) begin
                    cause_q  <= {28'd0, exc_code_i};
                    epc_q    <= exc_pc_i;
                    target_q <= MTVEC_BASE;
                end else if (take_irq) begin
                    cause_q  <= irq_cause;
                    epc_q    <= next_pc_i;
                    target_q <= irq_target;
                end else begin
                    cause_q  <= 32'd0;
                    epc_q    <= 32'd0;
                    target_q <= 32'd0;
                end
            end else if (state == RESTORE) begin
                target_q <= epc_i;
            end
        end
    end

    // Next-state logic. flush_ack_i only matters while in FLUSH.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (take_any) next_state = FLUSH;
            FLUSH:   if (flush_ack_i) next_state = is_mret_q ? RESTORE : SAVE;
            SAVE:    next_state = JUMP;
            RESTORE: next_state = JUMP;
            JUMP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Moore outputs. Each data bus is forced to zero unless its strobe is high.
    always_comb begin
        flush_req_o    = 1'b0;
        save_epc_o     = 1'b0;
        epc_pc_o       = 32'd0;
        cause_o        = 32'd0;
        mret_restore_o = 1'b0;
        redirect_o     = 1'b0;
        redirect_pc_o  = 32'd0;
        busy_o         = (state != IDLE);
        case (state)
            FLUSH: flush_req_o = 1'b1;
            SAVE: begin
                save_epc_o = 1'b1;
                epc_pc_o   = epc_q;
                cause_o    = cause_q;
            end
            RESTORE: mret_restore_o = 1'b1;
            JUMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = target_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
// Self-checking bench for trap_ctrl. Each event that is driven pushes its
// expected save/restore and redirect pulses onto a scoreboard queue. A
// negedge monitor pops an entry every time the DUT produces a pulse and
// compares the two. Timing, priority, the ignored-while-busy rule and
// mid-sequence reset are checked directly in the stimulus flow.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam int          NUM_IRQ    = 4;
    localparam logic [31:0] MTVEC_BASE = 32'h0000_0100;

    localparam logic [1:0] K_SAVE     = 2'd0;
    localparam logic [1:0] K_RESTORE  = 2'd1;
    localparam logic [1:0] K_REDIRECT = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               exc_valid_i;
    logic [3:0]         exc_code_i;
    logic [31:0]        exc_pc_i;
    logic               mret_i;
    logic [NUM_IRQ-1:0] irq_i;
    logic               mie_i;
    logic [31:0]        next_pc_i;
    logic [31:0]        epc_i;
    logic               flush_req_o;
    logic               flush_ack_i;
    logic               save_epc_o;
    logic [31:0]        epc_pc_o;
    logic               mret_restore_o;
    logic [31:0]        cause_o;
    logic               redirect_o;
    logic [31:0]        redirect_pc_o;
    logic               busy_o;

    exp_t expQueue[$];
    int   checkCount    = 0;
    int   passCount     = 0;
    int   redirectCount = 0;

    trap_ctrl #(
        .NUM_IRQ    (NUM_IRQ),
        .MTVEC_BASE (MTVEC_BASE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid_i    (exc_valid_i),
        .exc_code_i     (exc_code_i),
        .exc_pc_i       (exc_pc_i),
        .mret_i         (mret_i),
        .irq_i          (irq_i),
        .mie_i          (mie_i),
        .next_pc_i      (next_pc_i),
        .epc_i          (epc_i),
        .flush_req_o    (flush_req_o),
        .flush_ack_i    (flush_ack_i),
        .save_epc_o     (save_epc_o),
        .epc_pc_o       (epc_pc_o),
        .mret_restore_o (mret_restore_o),
        .cause_o        (cause_o),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Scoreboard monitor. Any strobe pops one expected entry. Data buses must
    // be zero whenever their strobe is low.
    always @(negedge clk) begin
        exp_t rec;
        logic [31:0] gated;
        gated = (save_epc_o ? 32'd0 : (epc_pc_o | cause_o)) |
                (redirect_o ? 32'd0 : redirect_pc_o);
        checkOutput("strobe_gated_data", gated, 32'd0);
        if (redirect_o) redirectCount++;
        if (save_epc_o || mret_restore_o || redirect_o) begin
            if (expQueue.size() == 0) begin
                checkOutput("unexpected_pulse",
                            {29'd0, redirect_o, mret_restore_o, save_epc_o}, 32'd0);
            end else begin
                rec = expQueue.pop_front();
                if (rec.kind == K_SAVE) begin
                    checkOutput("save_strobe", {31'd0, save_epc_o}, 32'd1);
                    checkOutput("save_epc", epc_pc_o, rec.a);
                    checkOutput("save_cause", cause_o, rec.b);
                end else if (rec.kind == K_RESTORE) begin
                    checkOutput("restore_strobe", {31'd0, mret_restore_o}, 32'd1);
                    checkOutput("restore_no_save", {31'd0, save_epc_o}, 32'd0);
                end else begin
                    checkOutput("redirect_strobe", {31'd0, redirect_o}, 32'd1);
                    checkOutput("redirect_pc", redirect_pc_o, rec.a);
                end
            end
        end
    end

    // Reference model: pushes the pulses that one accepted event should produce.
    task automatic pushExpected(input logic exc, input logic [3:0] code,
                                input logic [31:0] pc, input logic mret,
                                input logic [NUM_IRQ-1:0] irq, input logic mie,
                                input logic [31:0] npc, input logic [31:0] epc);
        int k;
        logic [31:0] tgt;
        if (exc) begin
            expQueue.push_back('{K_SAVE, pc, {28'd0, code}});
            expQueue.push_back('{K_REDIRECT, MTVEC_BASE, 32'd0});
        end else if (mret) begin
            expQueue.push_back('{K_RESTORE, 32'd0, 32'd0});
            expQueue.push_back('{K_REDIRECT, epc, 32'd0});
        end else if (mie && (|irq)) begin
            k = 0;
            while (!irq[k]) k++;
`ifdef VECTORED_MTVEC_EN
            tgt = MTVEC_BASE + 32'(4 * (16 + k));
`else
            tgt = MTVEC_BASE;
`endif
            expQueue.push_back('{K_SAVE, npc, 32'h8000_0000 | 32'(16 + k)});
            expQueue.push_back('{K_REDIRECT, tgt, 32'd0});
        end
    endtask

    // Drives one event for a single cycle and then runs the whole sequence.
    // lateExc keeps exc_valid_i high through FLUSH, where it has to be ignored.
    task automatic applyStimulus(input logic exc, input logic [3:0] code,
                                 input logic [31:0] pc, input logic mret,
                                 input logic [NUM_IRQ-1:0] irq, input logic mie,
                                 input logic [31:0] npc, input logic [31:0] epc,
                                 input int ackDelay, input logic lateExc);
        pushExpected(exc, code, pc, mret, irq, mie, npc, epc);
        @(posedge clk) #1;
        exc_valid_i = exc;
        exc_code_i  = code;
        exc_pc_i    = pc;
        mret_i      = mret;
        irq_i       = irq;
        mie_i       = mie;
        next_pc_i   = npc;
        epc_i       = epc;
        @(posedge clk) #1;
        exc_valid_i = lateExc;
        exc_code_i  = lateExc ? 4'hB : 4'h0;
        exc_pc_i    = lateExc ? 32'hDEAD_0000 : 32'd0;
        mret_i      = 1'b0;
        irq_i       = '0;
        @(negedge clk);
        checkOutput("flush_req_start", {31'd0, flush_req_o}, 32'd1);
        checkOutput("busy_start", {31'd0, busy_o}, 32'd1);
        for (int i = 0; i < ackDelay; i++) begin
            @(posedge clk) #1;
            @(negedge clk);
            checkOutput("flush_req_hold", {31'd0, flush_req_o}, 32'd1);
        end
        exc_valid_i = 1'b0;
        flush_ack_i = 1'b1;
        @(posedge clk) #1;
        flush_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("pulse_latency", {31'd0, save_epc_o | mret_restore_o}, 32'd1);
        checkOutput("flush_req_drop", {31'd0, flush_req_o}, 32'd0);
        @(negedge clk);
        checkOutput("redirect_latency", {31'd0, redirect_o}, 32'd1);
        @(negedge clk);
        checkOutput("busy_end", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int redirBefore;
        rst         = 1'b1;
        exc_valid_i = 1'b0;
        exc_code_i  = 4'h0;
        exc_pc_i    = 32'd0;
        mret_i      = 1'b0;
        irq_i       = '0;
        mie_i       = 1'b0;
        next_pc_i   = 32'd0;
        epc_i       = 32'd0;
        flush_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset_flush", {31'd0, flush_req_o}, 32'd0);
        checkOutput("reset_strobes",
                    {29'd0, redirect_o, mret_restore_o, save_epc_o}, 32'd0);

        $display("[TB] exception with delayed ack");
        applyStimulus(1'b1, 4'd2, 32'h80, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 3, 1'b0);

        $display("[TB] interrupt, lowest index wins");
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'b0110, 1'b1, 32'h44, 32'h0, 1, 1'b0);

        $display("[TB] masked interrupt");
        @(posedge clk) #1;
        irq_i = 4'b0001;
        mie_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("masked_flush", {31'd0, flush_req_o}, 32'd0);
            checkOutput("masked_busy", {31'd0, busy_o}, 32'd0);
        end
        @(posedge clk) #1;
        irq_i = '0;

        $display("[TB] mret with immediate ack");
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'b0000, 1'b0, 32'h0, 32'h200, 0, 1'b0);

        $display("[TB] simultaneous events and event while busy");
        redirBefore = redirectCount;
        applyStimulus(1'b1, 4'd7, 32'h1234, 1'b1, 4'b0001, 1'b1, 32'h88, 32'h300, 2, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("single_redirect", 32'(redirectCount - redirBefore), 32'd1);
        checkOutput("idle_after_busy_exc", {31'd0, busy_o}, 32'd0);
        mie_i = 1'b0;

        $display("[TB] interrupt index 3");
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'b1000, 1'b1, 32'h9C, 32'h0, 0, 1'b0);

        $display("[TB] reset while in FLUSH");
        redirBefore = redirectCount;
        @(posedge clk) #1;
        exc_valid_i = 1'b1;
        exc_code_i  = 4'd5;
        exc_pc_i    = 32'h500;
        @(posedge clk) #1;
        exc_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_flush", {31'd0, flush_req_o}, 32'd1);
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("mid_reset_flush", {31'd0, flush_req_o}, 32'd0);
        flush_ack_i = 1'b1;
        @(posedge clk) #1;
        flush_ack_i = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("no_pulse_after_reset", 32'(redirectCount - redirBefore), 32'd0);
        checkOutput("busy_after_reset", {31'd0, busy_o}, 32'd0);

        checkOutput("scoreboard_empty", 32'(expQueue.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
